return_prediction_checker: RTL and testbench
============================================

# return_prediction_checker

Tracks every return-address prediction made in fetch until the matching return resolves in execution, then flags mispredictions. Sits directly downstream of the return address stack in if_stage_1. It captures the stack's popped address when fetch predicts a return. It compares that address against the resolved JALR target, and drives the mispredict/redirect pair that steers the next-PC mux.

## Interface
Parameters:
- DEPTH, 4, maximum in-flight predicted returns; power of two, ≥2

Ports:
- clk_i  in  1  clock; all state on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- fetch_ret_valid_i  in  1  fetch predicted a return this cycle (same cycle as RAS pop)
- predicted_addr_i  in  addrPC_t  address from the RAS, valid with fetch_ret_valid_i
- exe_ret_valid_i  in  1  a return resolved in execution this cycle
- exe_target_i  in  addrPC_t  resolved return target, valid with exe_ret_valid_i
- flush_i  in  1  pipeline flush; kills all in-flight predictions
- full_o  out  1  queue holds DEPTH entries; fetch must stall returns
- mispredict_o  out  1  one-cycle pulse: last resolved return was mispredicted
- correct_pc_o  out  addrPC_t  redirect target, valid with mispredict_o

## Operation
- Circular FIFO of DEPTH addrPC_t entries, with rd_ptr, wr_ptr ($clog2(DEPTH) bits, natural wrap) and count ($clog2(DEPTH)+1 bits).
- Enqueue: fetch_ret_valid_i && !full_o writes predicted_addr_i at wr_ptr, then wr_ptr+1.
- Enqueue while full is dropped silently; upstream is required to stall.
- Dequeue: exe_ret_valid_i && count≠0 reads the entry at rd_ptr, then rd_ptr+1.
  - Entry == exe_target_i: hit, no output pulse.
  - Entry ≠ exe_target_i: miss. Next cycle mispredict_o=1 and correct_pc_o=exe_target_i. The whole queue is cleared in the same edge (ptrs=0, count=0), because younger predictions are on the wrong path.
- exe_ret_valid_i with count==0 counts as a miss: pulse plus redirect to exe_target_i.
- Enqueue and hit dequeue in the same cycle: both occur, count unchanged.
- Enqueue and miss in the same cycle: clear wins, enqueue discarded.
- full_o depends only on count (count==DEPTH), never on the same-cycle dequeue. Enqueue while full is dropped even if a dequeue happens that cycle.
- flush_i has top priority: clears queue, suppresses any compare that cycle. mispredict_o is 0 the next cycle.
- Entry contents are not reset; only pointers and count are.

## Timing
- Reset (async assert, sync-released use): count=0, ptrs=0, full_o=0, mispredict_o=0, correct_pc_o=0.
- Reset mid-operation discards all entries immediately.
- full_o is combinational from the count register. It reflects an enqueue one cycle after the accepting edge.
- Compare-to-pulse latency is 1 cycle; mispredict_o and correct_pc_o are registered.
- mispredict_o lasts exactly one cycle. correct_pc_o holds its last value when mispredict_o=0.
- Back-to-back resolves are supported: one compare per cycle, pulses on consecutive cycles possible.

## Configuration
- RET_CHECK_PERF_EN defined: adds output ports hit_count_o and miss_count_o (32 bits each).
  - Both reset to 0 and wrap on overflow.
  - hit_count_o increments on each hit; miss_count_o on each miss, including empty-queue misses.
  - Neither counter increments on a flushed compare.
- Undefined: ports and counters are absent; functional behaviour is identical.

## Structure
- addrPC_t is taken from drac_pkg.
- Add to drac_pkg: RET_CHECK_DEPTH constant (default 4), used by the instantiating stage for DEPTH.
- Sub-module ret_pred_fifo: parameterised circular buffer with push/pop/clear, count and full/empty. The checker holds the compare, priority and output registers.

## Test plan
- Reset, then predict 0x1000, resolve 0x1000 → no pulse; count 1→0; hit_count_o=1 with macro.
- Predict 0x2000, resolve 0x2004 → next cycle mispredict_o=1, correct_pc_o=0x2004 for one cycle; count=0.
- Predict 4 returns with DEPTH=4 → full_o=1; 5th predict dropped. Resolve all 4 in order → FIFO order preserved, pointers wrap cleanly.
- 3 predictions queued, first resolves as miss while fetch predicts 0x3000 → queue empty, 0x3000 not stored, one pulse.
- flush_i asserted with exe_ret_valid_i and a wrong target → no pulse, count=0, counters unchanged.
- exe_ret_valid_i with empty queue, target 0x4000 → pulse with correct_pc_o=0x4000. rstn_i asserted mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared core types: PC address type and return-prediction checker settings.
`timescale 1ns/1ps
package drac_pkg;

    localparam int unsigned ADDR_PC_W       = 40;
    localparam int unsigned RET_CHECK_DEPTH = 4;

    typedef logic [ADDR_PC_W-1:0] addrPC_t;

    typedef enum logic [1:0] {
        CMP_NONE,
        CMP_HIT,
        CMP_MISS
    } ret_cmp_e;

endpackage

// File: rtl/ret_pred_fifo.sv
// Circular buffer of predicted return addresses; clear has priority over push/pop.
`timescale 1ns/1ps
module ret_pred_fifo
    import drac_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clear_i,
    input  addrPC_t                  wdata_i,
    output addrPC_t                  rdata_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    addrPC_t            mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;
    logic               do_push, do_pop, empty;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // full is sampled from the registered count, so a same-cycle pop never frees a slot
    assign do_push = push_i && !full_o && !clear_i;
    assign do_pop  = pop_i && !empty && !clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/return_prediction_checker.sv
// Compares queued RAS predictions with resolved JALR targets and issues redirects.
// Define RET_CHECK_PERF_EN to add the hit_count_o / miss_count_o counters.
`timescale 1ns/1ps
module return_prediction_checker
    import drac_pkg::*;
#(
    parameter int unsigned DEPTH = RET_CHECK_DEPTH
) (
    input  logic    clk_i,
    input  logic    rstn_i,
    input  logic    fetch_ret_valid_i,
    input  addrPC_t predicted_addr_i,
    input  logic    exe_ret_valid_i,
    input  addrPC_t exe_target_i,
    input  logic    flush_i,
    output logic    full_o,
    output logic    mispredict_o,
    output addrPC_t correct_pc_o
`ifdef RET_CHECK_PERF_EN
   ,output logic [31:0] hit_count_o,
    output logic [31:0] miss_count_o
`endif
);

    ret_cmp_e                 cmp;
    addrPC_t                  head_addr;
    logic [$clog2(DEPTH):0]   fifo_count;
    logic                     fifo_empty;
    logic                     fifo_pop, fifo_clear;
    logic                     mispredict_q, mispredict_d;
    addrPC_t                  correct_pc_q, correct_pc_d;

    ret_pred_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .push_i  (fetch_ret_valid_i),
        .pop_i   (fifo_pop),
        .clear_i (fifo_clear),
        .wdata_i (predicted_addr_i),
        .rdata_o (head_addr),
        .count_o (fifo_count),
        .full_o  (full_o)
    );

    assign fifo_empty = (fifo_count == '0);

    // A resolve with nothing queued had no prediction to match, so it redirects.
    always_comb begin
        cmp = CMP_NONE;
        if (exe_ret_valid_i && !flush_i) begin
            if (fifo_empty || head_addr != exe_target_i) cmp = CMP_MISS;
            else                                         cmp = CMP_HIT;
        end
        fifo_pop     = (cmp == CMP_HIT);
        fifo_clear   = flush_i || (cmp == CMP_MISS);
        mispredict_d = (cmp == CMP_MISS);
        correct_pc_d = (cmp == CMP_MISS) ? exe_target_i : correct_pc_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            mispredict_q <= 1'b0;
            correct_pc_q <= '0;
        end else begin
            mispredict_q <= mispredict_d;
            correct_pc_q <= correct_pc_d;
        end
    end

    assign mispredict_o = mispredict_q;
    assign correct_pc_o = correct_pc_q;

`ifdef RET_CHECK_PERF_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (cmp == CMP_HIT)  hit_count_q  <= hit_count_q + 32'd1;
            if (cmp == CMP_MISS) miss_count_q <= miss_count_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_return_prediction_checker.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
`timescale 1ns/1ps
module tb_return_prediction_checker;
    import drac_pkg::*;

    localparam int unsigned DEPTH = 4;

    logic    clk_i;
    logic    rstn_i;
    logic    fetch_ret_valid_i;
    addrPC_t predicted_addr_i;
    logic    exe_ret_valid_i;
    addrPC_t exe_target_i;
    logic    flush_i;
    logic    full_o;
    logic    mispredict_o;
    addrPC_t correct_pc_o;
`ifdef RET_CHECK_PERF_EN
    logic [31:0] hit_count_o, miss_count_o;
`endif

    return_prediction_checker #(.DEPTH(DEPTH)) dut (
        .clk_i             (clk_i),
        .rstn_i            (rstn_i),
        .fetch_ret_valid_i (fetch_ret_valid_i),
        .predicted_addr_i  (predicted_addr_i),
        .exe_ret_valid_i   (exe_ret_valid_i),
        .exe_target_i      (exe_target_i),
        .flush_i           (flush_i),
        .full_o            (full_o),
        .mispredict_o      (mispredict_o),
        .correct_pc_o      (correct_pc_o)
`ifdef RET_CHECK_PERF_EN
       ,.hit_count_o       (hit_count_o),
        .miss_count_o      (miss_count_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    string       phase = "init";

    addrPC_t     model_q[$];
    addrPC_t     exp_pc = '0;
    int unsigned exp_hits = 0;
    int unsigned exp_miss = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%s]: got 0x%0h expected 0x%0h", tag, phase, act, exp);
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_pc   = '0;
        exp_hits = 0;
        exp_miss = 0;
    endtask

    task automatic check_counters();
`ifdef RET_CHECK_PERF_EN
        chk("hit_count", 64'(hit_count_o), 64'(exp_hits));
        chk("miss_count", 64'(miss_count_o), 64'(exp_miss));
`endif
    endtask

    // Entered #1 after a rising edge; returns #1 after the next one.
    task automatic step(input logic fv, input addrPC_t pa, input logic ev,
                        input addrPC_t et, input logic fl);
        bit miss;
        bit was_full;
        fetch_ret_valid_i = fv;
        predicted_addr_i  = pa;
        exe_ret_valid_i   = ev;
        exe_target_i      = et;
        flush_i           = fl;
        was_full = (model_q.size() == DEPTH);
        chk("full", 64'(full_o), 64'(was_full));
        miss = 1'b0;
        if (fl) begin
            model_q.delete();
        end else if (ev) begin
            if (model_q.size() == 0 || model_q[0] != et) begin
                miss = 1'b1;
            end else begin
                void'(model_q.pop_front());
                exp_hits++;
            end
        end
        if (miss) begin
            model_q.delete();
            exp_miss++;
            exp_pc = et;
        end
        if (fv && !fl && !miss && !was_full) model_q.push_back(pa);
        @(posedge clk_i);
        #1;
        chk("mispredict", 64'(mispredict_o), 64'(miss));
        chk("correct_pc", 64'(correct_pc_o), 64'(exp_pc));
        check_counters();
        fetch_ret_valid_i = 1'b0;
        exe_ret_valid_i   = 1'b0;
        flush_i           = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic predict(input addrPC_t a);
        step(1'b1, a, 1'b0, '0, 1'b0);
    endtask

    task automatic resolve(input addrPC_t t);
        step(1'b0, '0, 1'b1, t, 1'b0);
    endtask

    task automatic release_reset();
        @(negedge clk_i);
        rstn_i = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rstn_i            = 1'b0;
        fetch_ret_valid_i = 1'b0;
        predicted_addr_i  = '0;
        exe_ret_valid_i   = 1'b0;
        exe_target_i      = '0;
        flush_i           = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        phase = "reset";
        chk("rst_full", 64'(full_o), 64'd0);
        chk("rst_mispredict", 64'(mispredict_o), 64'd0);
        chk("rst_correct_pc", 64'(correct_pc_o), 64'd0);
        check_counters();
        release_reset();

        phase = "hit";
        predict(40'h1000);
        resolve(40'h1000);
        resolve(40'h1000);

        phase = "miss";
        predict(40'h2000);
        resolve(40'h2004);
        idle();

        phase = "fill";
        for (int i = 0; i < 4; i++) predict(40'hA000 + 40'(i * 4));
        predict(40'hB000);
        for (int i = 0; i < 4; i++) resolve(40'hA000 + 40'(i * 4));
        resolve(40'hB000);
        idle();

        phase = "miss_vs_enq";
        for (int i = 0; i < 3; i++) predict(40'hC000 + 40'(i * 4));
        step(1'b1, 40'h3000, 1'b1, 40'hDEAD, 1'b0);
        resolve(40'h3000);
        idle();

        phase = "enq_and_hit";
        predict(40'h5000);
        step(1'b1, 40'h5004, 1'b1, 40'h5000, 1'b0);
        resolve(40'h5004);

        phase = "flush";
        predict(40'h6000);
        step(1'b0, '0, 1'b1, 40'h6666, 1'b1);
        resolve(40'h6000);

        phase = "empty_miss";
        resolve(40'h4000);
        idle();

        phase = "random";
        for (int n = 0; n < 600; n++) begin
            logic    fv, ev, fl;
            addrPC_t pa, et;
            fv = 1'($urandom_range(0, 1));
            pa = addrPC_t'({$urandom_range(0, 15), 2'b00});
            ev = ($urandom_range(0, 2) != 0);
            if (model_q.size() > 0 && $urandom_range(0, 4) != 0) et = model_q[0];
            else                                                   et = addrPC_t'({$urandom_range(0, 15), 2'b00});
            fl = ($urandom_range(0, 29) == 0);
            step(fv, pa, ev, et, fl);
        end

        phase = "reset_pulse";
        predict(40'h7000);
        resolve(40'h7777);
        chk("pre_rst_pulse", 64'(mispredict_o), 64'd1);
        rstn_i = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_mispredict", 64'(mispredict_o), 64'd0);
        chk("rst_mid_correct_pc", 64'(correct_pc_o), 64'd0);
        check_counters();
        release_reset();

        phase = "reset_full";
        for (int i = 0; i < 4; i++) predict(40'h8000 + 40'(i * 4));
        chk("pre_rst_full", 64'(full_o), 64'd1);
        rstn_i = 1'b0;
        #1;
        model_reset();
        chk("rst_mid_full", 64'(full_o), 64'd0);
        check_counters();
        release_reset();
        resolve(40'h8000);
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
